bar_painter: RTL and testbench

//  Draws a parametrised horizontal level bar into the 1-bpp frame RAM: 1-px border, 1-px gap, then a fill proportional to `level`.

---
 rtl/bar_painter_pkg.sv | 24 ++
 rtl/bar_byte_gen.sv | 35 +++
 rtl/bar_painter.sv | 116 +++++++++++
 tb/tb_bar_painter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bar_painter_pkg.sv
// Shared screen constants and helpers for the 1-bpp frame RAM blocks.
// Pixel bit order: MSB of a byte is the leftmost pixel.
package bar_painter_pkg;

  localparam int SCR_ADDR_W    = 11;
  localparam int SCR_ROW_BYTES = 16;
  localparam int PX_PER_BYTE   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAINT,
    ST_DONE
  } state_t;

  // screen pixel index of bit b in byte column col (MSB = left pixel)
  function automatic int px_index(input int col, input int b);
    return PX_PER_BYTE * col + (PX_PER_BYTE - 1 - b);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bar_byte_gen.sv
// Combinational pattern byte for one (row, byte column) cell of the level bar:
// 1-px border, 1-px gap, fill of `level` pixels starting at pixel 2.
module bar_byte_gen
  import bar_painter_pkg::*;
#(
  parameter int BAR_BYTES = 12,
  parameter int BAR_ROWS  = 10,
  parameter int LEVEL_W   = 8,
  parameter int RW        = cnt_w(BAR_ROWS),
  parameter int CW        = cnt_w(BAR_BYTES)
) (
  input  logic [RW-1:0]      r,
  input  logic [CW-1:0]      c,
  input  logic [LEVEL_W-1:0] level,
  output logic [7:0]         pattern
);

  localparam int W = PX_PER_BYTE * BAR_BYTES;

  always_comb begin
    int ri;
    int p;
    pattern = '0;
    ri      = int'(r);
    p       = 0;
    for (int b = 0; b < 8; b++) begin
      p = px_index(int'(c), b);
      pattern[b] = (ri == 0) || (ri == BAR_ROWS - 1) ||
                   (p == 0)  || (p == W - 1) ||
                   ((ri >= 2) && (ri <= BAR_ROWS - 3) &&
                    (p >= 2) && (p <= 1 + int'(level)));
    end
  end

endmodule

// File: rtl/bar_painter.sv
// Sweeps the bar's byte grid after a start pulse, issuing one frame-RAM
// byte write per clock; level is clamped and latched when start is accepted.
module bar_painter
  import bar_painter_pkg::*;
#(
  parameter int ADDR_W    = SCR_ADDR_W,
  parameter int ROW_BYTES = SCR_ROW_BYTES,
  parameter int X_BYTE    = 2,
  parameter int Y_TOP     = 29,
  parameter int BAR_BYTES = 12,
  parameter int BAR_ROWS  = 10,
  parameter int LEVEL_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEVEL_W-1:0] level,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int RW   = cnt_w(BAR_ROWS);
  localparam int CW   = cnt_w(BAR_BYTES);
  localparam int LMAX = PX_PER_BYTE * BAR_BYTES - 4;

  state_t             state, state_nxt;
  logic [RW-1:0]      r;
  logic [CW-1:0]      c;
  logic [LEVEL_W-1:0] lvl;
  logic [LEVEL_W-1:0] lvl_clamped;
  logic [7:0]         pattern;
  logic               last;
  logic               row_end;

  assign row_end     = (int'(c) == BAR_BYTES - 1);
  assign last        = row_end && (int'(r) == BAR_ROWS - 1);
  assign lvl_clamped = (int'(level) > LMAX) ? LEVEL_W'(LMAX) : level;

  bar_byte_gen #(
    .BAR_BYTES (BAR_BYTES),
    .BAR_ROWS  (BAR_ROWS),
    .LEVEL_W   (LEVEL_W),
    .RW        (RW),
    .CW        (CW)
  ) u_byte_gen (
    .r       (r),
    .c       (c),
    .level   (lvl),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_PAINT;
      ST_PAINT: if (last)  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the current cell, so the write for the
  // cell selected at edge k appears after edge k+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r       <= '0;
      c       <= '0;
      lvl     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            r   <= '0;
            c   <= '0;
            lvl <= lvl_clamped;
          end
        end
        ST_PAINT: begin
          busy    <= 1'b1;
          wr_en   <= 1'b1;
          wr_data <= pattern;
          wr_addr <= ADDR_W'((Y_TOP + int'(r)) * ROW_BYTES + X_BYTE + int'(c));
          if (row_end) begin
            c <= '0;
            r <= r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        ST_DONE: begin
          busy <= 1'b1;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bar_painter.sv
// Self-checking bench for bar_painter: scoreboard of expected writes plus
// a table of spot-check bytes against a shadow copy of the frame RAM.
module tb_bar_painter;

  localparam int N    = 120;
  localparam int LMAX = 92;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  level;
  logic        busy, done, wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  bar_painter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .level   (level),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    int lvl;
    int addr;
    int data;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       vt[$];
  logic [7:0] shadow [0:2047];
  int         pass_cnt = 0;
  int         tot_cnt  = 0;
  int         done_cnt = 0;
  int         wr_cnt   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  // Reference pixel model for a 96x10 bar.
  function automatic logic [7:0] mdl(input int r, input int c, input int lv);
    logic [7:0] v;
    int p;
    int l;
    l = (lv > LMAX) ? LMAX : lv;
    v = 8'h00;
    for (int b = 0; b < 8; b++) begin
      p = 8 * c + 7 - b;
      if (r == 0 || r == 9 || p == 0 || p == 95 || (r >= 2 && r <= 7 && p >= 2 && p <= 1 + l))
        v[b] = 1'b1;
    end
    return v;
  endfunction

  task automatic push_paint(input int lv);
    exp_t e;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 12; c++) begin
        e.addr = 11'((29 + r) * 16 + 2 + c);
        e.data = mdl(r, c, lv);
        exp_q.push_back(e);
      end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) done_cnt++;
      if (wr_en) begin
        wr_cnt++;
        shadow[wr_addr] = wr_data;
        if (!busy) chk("busy_during_write", busy, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end
    end
  end

  // Called just after a negedge; returns just after the negedge that ends the done pulse.
  task automatic paint(input int lv, input bit noisy);
    int cyc;
    int d0;
    d0 = done_cnt;
    push_paint(lv);
    start = 1'b1;
    level = 8'(lv);
    @(negedge clk);
    start = 1'b0;
    chk("busy_before_first_write", busy, 0);
    chk("wr_en_before_first_write", wr_en, 0);
    cyc = 0;
    while (!done && cyc <= 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("first_write_en", wr_en, 1);
        chk("first_write_addr", wr_addr, 466);
      end
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        level = 8'($urandom);
      end
    end
    start = 1'b0;
    if (cyc > 400) chk("done_timeout", 0, 1);
    chk("done_latency", cyc, N + 1);
    chk("done_wr_en_low", wr_en, 0);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int snap;
    rst_n = 1'b0;
    start = 1'b0;
    level = 8'd0;
    for (int i = 0; i < 2048; i++) shadow[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, wr_en, wr_addr, wr_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vt.push_back('{0, 466, 'hFF});  vt.push_back('{0, 477, 'hFF});
    vt.push_back('{0, 482, 'h80});  vt.push_back('{0, 483, 'h00});
    vt.push_back('{0, 492, 'h00});  vt.push_back('{0, 493, 'h01});
    vt.push_back('{0, 498, 'h80});  vt.push_back('{0, 610, 'hFF});
    vt.push_back('{0, 621, 'hFF});
    vt.push_back('{92, 498, 'hBF}); vt.push_back('{92, 499, 'hFF});
    vt.push_back('{92, 508, 'hFF}); vt.push_back('{92, 509, 'hFD});
    vt.push_back('{92, 482, 'h80}); vt.push_back('{92, 493, 'h01});
    vt.push_back('{92, 578, 'hBF}); vt.push_back('{92, 589, 'hFD});
    vt.push_back('{92, 594, 'h80});
    vt.push_back('{200, 498, 'hBF}); vt.push_back('{200, 499, 'hFF});
    vt.push_back('{200, 509, 'hFD}); vt.push_back('{200, 578, 'hBF});
    vt.push_back('{6, 498, 'hBF});  vt.push_back('{6, 499, 'h00});
    vt.push_back('{10, 498, 'hBF}); vt.push_back('{10, 499, 'hF0});

    for (int i = 0; i < vt.size(); i++) begin
      if (i == 0 || vt[i].lvl != vt[i-1].lvl) paint(vt[i].lvl, 1'b0);
      chk($sformatf("vec%0d_lvl%0d_addr%0d", i, vt[i].lvl, vt[i].addr),
          shadow[vt[i].addr], vt[i].data);
    end

    // start/level noise during a paint, then a fresh start right after done
    paint(40, 1'b1);
    paint(30, 1'b0);

    // reset in the middle of a paint
    push_paint(50);
    start = 1'b1;
    level = 8'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midpaint_reset_outputs", {busy, done, wr_en, wr_addr, wr_data}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    snap = wr_cnt;
    repeat (150) @(negedge clk);
    chk("no_writes_after_reset", wr_cnt - snap, 0);
    chk("idle_after_reset", {busy, done}, 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
